lru_replacement_unit: RTL and testbench

- True-LRU replacement state for a set-associative cache.
- Tracks per-set way ages, updated on every hit or fill, and returns the victim way as a one-hot vector.
- The victim vector feeds the cache's one_hot_decoder, which converts it to a binary way index for the tag/data array write.
- Sits between the cache controller FSM (lookup/update requests) and the way-select decode path.

---
 rtl/cache_repl_pkg.sv | 28 ++
 rtl/lru_replacement_unit_if.sv | 33 +++
 rtl/lru_age_next.sv | 34 +++
 rtl/lru_replacement_unit.sv | 109 ++++++++++
 tb/tb_lru_replacement_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_repl_pkg.sv
// Shared helpers for the cache replacement logic: width derivation and
// one-hot detection. Used by lru_replacement_unit, its interface and lru_age_next.
package cache_repl_pkg;

  // Widest way vector the one-hot checker accepts.
  localparam int unsigned MAX_WAYS = 64;

  // Ceiling log2. A value of 1 maps to 0.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Width of an age counter, binary way index or set index (never zero).
  function automatic int unsigned field_width(input int unsigned n);
    return (n < 2) ? 1 : log2(n);
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_one_hot(input logic [MAX_WAYS-1:0] v);
    return (v != '0) && ((v & (v - MAX_WAYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/lru_replacement_unit_if.sv
// Request/response bundle between the cache controller and the LRU unit.
interface lru_replacement_unit_if import cache_repl_pkg::*; #(
  parameter int unsigned NUMBER_OF_WAYS = 8,
  parameter int unsigned NUMBER_OF_SETS = 16
) ();

  localparam int unsigned INDEX_BITS = field_width(NUMBER_OF_SETS);

  logic                      lookup_valid;
  logic [INDEX_BITS-1:0]     lookup_index;
  logic [NUMBER_OF_WAYS-1:0] way_valid_bits;
  logic                      update_valid;
  logic [INDEX_BITS-1:0]     update_index;
  logic [NUMBER_OF_WAYS-1:0] update_way;
  logic                      victim_valid;
  logic [NUMBER_OF_WAYS-1:0] victim_way;
  logic                      update_error;

  // Cache controller side.
  modport master (
    output lookup_valid, lookup_index, way_valid_bits,
    output update_valid, update_index, update_way,
    input  victim_valid, victim_way, update_error
  );

  // Replacement unit side.
  modport slave (
    input  lookup_valid, lookup_index, way_valid_bits,
    input  update_valid, update_index, update_way,
    output victim_valid, victim_way, update_error
  );

endinterface

// File: rtl/lru_age_next.sv
// Combinational true-LRU age update for one set: the accessed way becomes
// age 0 and every way younger than it ages by one.
module lru_age_next import cache_repl_pkg::*; #(
  parameter  int unsigned NUMBER_OF_WAYS = 8,
  localparam int unsigned WAY_BITS       = field_width(NUMBER_OF_WAYS)
) (
  input  logic [NUMBER_OF_WAYS-1:0][WAY_BITS-1:0] ages_i,
  input  logic [NUMBER_OF_WAYS-1:0]               access_i,
  output logic [NUMBER_OF_WAYS-1:0][WAY_BITS-1:0] ages_o
);

  logic [WAY_BITS-1:0] hit_age_c;

  // Old age of the accessed way (access is one-hot, so an OR-select suffices).
  always_comb begin
    hit_age_c = '0;
    for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
      if (access_i[w]) hit_age_c = hit_age_c | ages_i[w];
    end
  end

  // Promote the accessed way, age the ways that were more recent than it.
  always_comb begin
    ages_o = ages_i;
    for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
      if (access_i[w]) begin
        ages_o[w] = '0;
      end else if (ages_i[w] < hit_age_c) begin
        ages_o[w] = ages_i[w] + WAY_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/lru_replacement_unit.sv
// True-LRU replacement state for a set-associative cache. Holds per-set way
// ages, applies hit/fill updates and returns a registered one-hot victim.
// Optional feature macro: LRU_INVALID_FIRST_EN (prefer lowest invalid way).
module lru_replacement_unit import cache_repl_pkg::*; #(
  parameter int unsigned NUMBER_OF_WAYS = 8,
  parameter int unsigned NUMBER_OF_SETS = 16
) (
  input logic                   clock,
  input logic                   reset,
  lru_replacement_unit_if.slave bus
);

  localparam int unsigned WAY_BITS   = field_width(NUMBER_OF_WAYS);
  localparam int unsigned INDEX_BITS = field_width(NUMBER_OF_SETS);

  typedef logic [NUMBER_OF_WAYS-1:0][WAY_BITS-1:0] set_ages_t;

  set_ages_t                 age_q [NUMBER_OF_SETS];
  set_ages_t                 age_d [NUMBER_OF_SETS];
  set_ages_t                 upd_cur_c;
  set_ages_t                 upd_next_c;
  set_ages_t                 lk_ages_c;
  logic                      upd_one_hot_c;
  logic                      upd_ok_c;
  logic                      bypass_c;
  logic [NUMBER_OF_WAYS-1:0] lru_way_c;
  logic [NUMBER_OF_WAYS-1:0] victim_c;
  logic                      victim_valid_q, victim_valid_d;
  logic [NUMBER_OF_WAYS-1:0] victim_way_q,   victim_way_d;
  logic                      update_error_q, update_error_d;

  assign upd_one_hot_c = is_one_hot(MAX_WAYS'(bus.update_way));
  assign upd_ok_c      = bus.update_valid && upd_one_hot_c;
  assign upd_cur_c     = age_q[bus.update_index];

  // Single age-update datapath shared by the state write and the lookup bypass.
  lru_age_next #(
    .NUMBER_OF_WAYS (NUMBER_OF_WAYS)
  ) u_age_next (
    .ages_i   (upd_cur_c),
    .access_i (bus.update_way),
    .ages_o   (upd_next_c)
  );

  // Lookup sees post-update ages when it hits the set being written this cycle.
  assign bypass_c  = upd_ok_c && (bus.update_index == bus.lookup_index);
  assign lk_ages_c = bypass_c ? upd_next_c : age_q[bus.lookup_index];

  // The oldest way carries the maximum age; ages are a permutation, so one-hot.
  always_comb begin
    lru_way_c = '0;
    for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
      lru_way_c[w] = (lk_ages_c[w] == WAY_BITS'(NUMBER_OF_WAYS - 1));
    end
  end

`ifdef LRU_INVALID_FIRST_EN
  logic [NUMBER_OF_WAYS-1:0] invalid_c;

  // Lowest-numbered invalid way wins over LRU; isolate it with x & -x.
  assign invalid_c = ~bus.way_valid_bits;
  assign victim_c  = (invalid_c != '0) ? (invalid_c & (~invalid_c + NUMBER_OF_WAYS'(1)))
                                       : lru_way_c;
`else
  logic unused_way_valid_c;

  // Valid bits play no part in pure-LRU selection.
  assign unused_way_valid_c = ^bus.way_valid_bits;
  assign victim_c           = lru_way_c;
`endif

  // Next-state for ages, victim register and error pulse.
  always_comb begin
    age_d          = age_q;
    victim_valid_d = bus.lookup_valid;
    victim_way_d   = victim_way_q;
    update_error_d = bus.update_valid && !upd_one_hot_c;
    if (upd_ok_c) begin
      age_d[bus.update_index] = upd_next_c;
    end
    if (bus.lookup_valid) begin
      victim_way_d = victim_c;
    end
  end

  // State flops; reset leaves way 0 as LRU in every set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NUMBER_OF_SETS; s++) begin
        for (int unsigned w = 0; w < NUMBER_OF_WAYS; w++) begin
          age_q[s][w] <= WAY_BITS'(NUMBER_OF_WAYS - 1 - w);
        end
      end
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      update_error_q <= 1'b0;
    end else begin
      age_q          <= age_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      update_error_q <= update_error_d;
    end
  end

  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;
  assign bus.update_error = update_error_q;

endmodule

// File: tb/tb_lru_replacement_unit.sv
// Bench for lru_replacement_unit (8 ways, 16 sets): directed vector table,
// reset-in-flight sequence, then random traffic against a recency-list model.
module tb_lru_replacement_unit;

  localparam int NW = 8;
  localparam int NS = 16;

  logic clock;
  logic reset;

  lru_replacement_unit_if #(.NUMBER_OF_WAYS(NW), .NUMBER_OF_SETS(NS)) bus ();

  lru_replacement_unit #(
    .NUMBER_OF_WAYS (NW),
    .NUMBER_OF_SETS (NS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       uv;
    logic [3:0] ui;
    logic [7:0] uw;
    logic       lv;
    logic [3:0] li;
    logic [7:0] vb;
    logic       e_vv;
    logic [7:0] e_vw;
    logic       e_ue;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  // Reference model: per set, ways ordered from most to least recently used.
  int         lst [NS][NW];
  logic       exp_vv;
  logic [7:0] exp_vw;
  logic       exp_ue;

  function automatic vec_t mk(logic uv, logic [3:0] ui, logic [7:0] uw, logic lv,
                              logic [3:0] li, logic [7:0] vb, logic e_vv,
                              logic [7:0] e_vw, logic e_ue);
    vec_t v;
    v.uv = uv; v.ui = ui; v.uw = uw; v.lv = lv; v.li = li; v.vb = vb;
    v.e_vv = e_vv; v.e_vw = e_vw; v.e_ue = e_ue;
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < NW; k++) lst[s][k] = NW - 1 - k;
    exp_vv = 1'b0;
    exp_vw = '0;
    exp_ue = 1'b0;
  endtask

  task automatic model_access(input int s, input logic [7:0] uw);
    int w;
    int p;
    w = 0;
    p = 0;
    for (int i = 0; i < NW; i++) if (uw[i]) w = i;
    for (int k = 0; k < NW; k++) if (lst[s][k] == w) p = k;
    for (int k = p; k > 0; k--) lst[s][k] = lst[s][k-1];
    lst[s][0] = w;
  endtask

  function automatic logic [7:0] model_victim(input int s, input logic [7:0] vb);
    logic [7:0] r;
    r = '0;
`ifdef LRU_INVALID_FIRST_EN
    if (vb != 8'hFF) begin
      for (int i = NW - 1; i >= 0; i--) if (!vb[i]) begin r = '0; r[i] = 1'b1; end
      return r;
    end
`else
    if (vb == 8'h5A) r = '0;
`endif
    r[lst[s][NW-1]] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, advance the model across the edge, settle.
  task automatic step(input logic uv, input logic [3:0] ui, input logic [7:0] uw,
                      input logic lv, input logic [3:0] li, input logic [7:0] vb);
    bus.update_valid   = uv;
    bus.update_index   = ui;
    bus.update_way     = uw;
    bus.lookup_valid   = lv;
    bus.lookup_index   = li;
    bus.way_valid_bits = vb;
    @(posedge clock);
    exp_ue = uv && ($countones(uw) != 1);
    if (uv && $countones(uw) == 1) model_access(int'(ui), uw);
    exp_vv = lv;
    if (lv) exp_vw = model_victim(int'(li), vb);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".victim_valid"}, 8'(bus.victim_valid), 8'(exp_vv));
    chk({tag, ".victim_way"},   bus.victim_way,       exp_vw);
    chk({tag, ".update_error"}, 8'(bus.update_error), 8'(exp_ue));
  endtask

  initial begin
    logic [7:0] w1h;
    // Directed table: expected values derived by hand from the LRU rules.
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 8'hFF, 1, 8'h01, 0));
    vecs.push_back(mk(1, 3, 8'h01, 0, 0, 8'hFF, 0, 8'h01, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 8'hFF, 1, 8'h02, 0));
    for (int i = 1; i < NW; i++) begin
      w1h = '0;
      w1h[i] = 1'b1;
      vecs.push_back(mk(1, 3, w1h, 0, 0, 8'hFF, 0, 8'h02, 0));
    end
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 8'hFF, 1, 8'h01, 0));
    vecs.push_back(mk(1, 3, 8'h80, 1, 3, 8'hFF, 1, 8'h01, 0));
    vecs.push_back(mk(1, 5, 8'h01, 1, 5, 8'hFF, 1, 8'h02, 0));
    vecs.push_back(mk(1, 5, 8'h04, 1, 6, 8'hFF, 1, 8'h01, 0));
    vecs.push_back(mk(1, 2, 8'h03, 0, 0, 8'hFF, 0, 8'h01, 1));
    vecs.push_back(mk(1, 2, 8'h00, 0, 0, 8'hFF, 0, 8'h01, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2, 8'hFF, 1, 8'h01, 0));
    vecs.push_back(mk(0, 2, 8'h03, 0, 0, 8'hFF, 0, 8'h01, 0));
`ifdef LRU_INVALID_FIRST_EN
    vecs.push_back(mk(0, 0, 8'h00, 1, 5, 8'h00, 1, 8'h01, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hEF, 1, 8'h10, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hFF, 1, 8'h01, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 5, 8'hFF, 1, 8'h02, 0));
`else
    vecs.push_back(mk(0, 0, 8'h00, 1, 5, 8'h00, 1, 8'h02, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'hEF, 1, 8'h01, 0));
`endif

    reset              = 1'b0;
    bus.update_valid   = 1'b0;
    bus.update_index   = '0;
    bus.update_way     = '0;
    bus.lookup_valid   = 1'b0;
    bus.lookup_index   = '0;
    bus.way_valid_bits = 8'hFF;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset.victim_valid", 8'(bus.victim_valid), 8'h00);
    chk("reset.victim_way",   bus.victim_way,       8'h00);
    chk("reset.update_error", 8'(bus.update_error), 8'h00);
    reset = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].uv, vecs[i].ui, vecs[i].uw, vecs[i].lv, vecs[i].li, vecs[i].vb);
      chk($sformatf("vec%0d.victim_valid", i), 8'(bus.victim_valid), 8'(vecs[i].e_vv));
      chk($sformatf("vec%0d.victim_way", i),   bus.victim_way,       vecs[i].e_vw);
      chk($sformatf("vec%0d.update_error", i), 8'(bus.update_error), 8'(vecs[i].e_ue));
    end

    // Reset in the middle of traffic on set 7.
    step(1, 7, 8'h10, 1, 7, 8'hFF);
    step(1, 7, 8'h01, 0, 0, 8'hFF);
    step(1, 7, 8'h02, 0, 0, 8'hFF);
    bus.update_valid = 1'b1;
    bus.update_index = 4'd7;
    bus.update_way   = 8'h03;
    bus.lookup_valid = 1'b1;
    bus.lookup_index = 4'd7;
    reset = 1'b0;
    #1;
    chk("midrst.async_victim_valid", 8'(bus.victim_valid), 8'h00);
    chk("midrst.async_victim_way",   bus.victim_way,       8'h00);
    chk("midrst.async_update_error", 8'(bus.update_error), 8'h00);
    @(posedge clock);
    #1;
    chk("midrst.held_victim_valid", 8'(bus.victim_valid), 8'h00);
    reset = 1'b1;
    model_reset();
    step(0, 0, 8'h00, 1, 7, 8'hFF);
    chk("midrst.after_victim_valid", 8'(bus.victim_valid), 8'h01);
    chk("midrst.after_victim_way",   bus.victim_way,       8'h01);

    // Random traffic on a few sets so same-index collisions are frequent.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] uw;
      logic [7:0] vb;
      if ($urandom_range(0, 7) == 0) uw = 8'($urandom);
      else begin uw = '0; uw[$urandom_range(0, NW - 1)] = 1'b1; end
      vb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), uw,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), vb);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
